lcd_cfah_cmd_sched: RTL
=======================

LCD_CFAH_CMD_SCHED -- requirements
Module: lcd_cfah_cmd_sched

Interface
REQ-001 Parameter G_TIMEOUT_CYCLES, default 1000000, maximum clk cycles to wait for i_control_done per command (20 ms at 50 MHz).
REQ-002 Parameter G_CNT_WIDTH, default 24, width of the timeout counter; SHALL satisfy 2**G_CNT_WIDTH > G_TIMEOUT_CYCLES.
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req_clear  in  1  one-cycle request: clear display.
REQ-006 i_req_dctrl  in  1  one-cycle request: re-apply display control (i_lcd_on/i_dcb owned by lcd_cfah_top).
REQ-007 i_req_cgram  in  1  one-cycle request: rewrite all CGRAM characters.
REQ-008 i_req_line  in  2  one-cycle requests: bit0 refresh line 0, bit1 refresh line 1.
REQ-009 i_control_done  in  1  one-cycle completion pulse from lcd_cfah_top.
REQ-010 o_start_init, o_display_ctrl_cmd, o_clear_display_cmd, o_update_lcd, o_update_cgram  out  1 each  one-cycle command pulses to lcd_cfah_top.
REQ-011 o_lcd_all_char  out  1  all-character flag for line update; o_lcd_line_sel  out  1  line select.
REQ-012 o_cgram_all_char  out  1  all-character flag for CGRAM update.
REQ-013 o_busy  out  1  command outstanding; o_init_done  out  1  power-up sequence complete.
REQ-014 o_timeout_err  out  1  sticky, a command timed out.

Function
REQ-015 FSM states: S_BOOT, S_ISSUE, S_WAIT, S_IDLE.
REQ-016 After reset, the block SHALL automatically issue, in order, INIT, DCTRL, CLEAR, each run as a single ISSUE/WAIT pair; o_init_done SHALL go to 1 in the cycle after the CLEAR command completes.
REQ-017 S_ISSUE SHALL last exactly one cycle and assert exactly one command pulse (registered output), then enter S_WAIT.
REQ-018 S_WAIT SHALL exit to the next boot step or S_IDLE on i_control_done=1.
REQ-019 i_control_done SHALL be ignored in any state other than S_WAIT.
REQ-020 Each request input SHALL set its own pending flag (5 flags total); requests are accepted during boot and while busy.
REQ-021 In S_IDLE with o_init_done=1, fixed priority SHALL apply: CLEAR > DCTRL > CGRAM > LINE0 > LINE1.
REQ-022 The granted pending flag SHALL clear in the S_IDLE->S_ISSUE cycle.
REQ-023 A new request on the same source in that same cycle SHALL win, leaving the flag set.
REQ-024 LINE0/LINE1 grant SHALL drive o_lcd_all_char=1 and o_lcd_line_sel=0/1; CGRAM grant SHALL drive o_cgram_all_char=1.
REQ-025 Selectors SHALL be stable from S_ISSUE until leaving S_WAIT, and 0 otherwise.
REQ-026 o_busy SHALL be 1 in S_BOOT, S_ISSUE and S_WAIT, and 0 in S_IDLE.
REQ-027 Minimum gap between consecutive command pulses: 2 cycles (done cycle, then idle/grant).
REQ-028 The timeout counter SHALL clear on S_ISSUE and increment in S_WAIT; reaching G_TIMEOUT_CYCLES-1 without done SHALL set o_timeout_err, abandon the command (no retry) and proceed as if done.
REQ-029 o_timeout_err SHALL clear only on rst.
REQ-030 A timeout during boot SHALL still complete the boot sequence and set o_init_done.

Reset
REQ-031 On rst=1 at a clock edge: FSM to S_BOOT, all pending flags and counter cleared; all outputs 0 except o_busy=1.
REQ-032 Reset mid-command SHALL abandon that command; after rst deasserts, the boot sequence SHALL restart from INIT.

Structure
REQ-033 Package lcd_cfah_sched_pkg SHALL hold the FSM state enum, the command enum (CMD_INIT, CMD_DCTRL, CMD_CLEAR, CMD_CGRAM, CMD_LINE0, CMD_LINE1), and the priority order constants.
REQ-034 One sub-module, lcd_cfah_prio_enc (5-bit pending vector in, one-hot grant out), SHALL implement the arbitration.

Verification
REQ-035 Reset release with done returned 10 cycles after each pulse -> pulses o_start_init, o_display_ctrl_cmd, o_clear_display_cmd in order, each 1 cycle wide; o_init_done=1 one cycle after the third done.
REQ-036 Simultaneous i_req_line=2'b11 and i_req_cgram in S_IDLE -> commands issued in order CGRAM, LINE0 (line_sel=0), LINE1 (line_sel=1), with no overlap.
REQ-037 i_req_line[0] pulsed in the grant cycle of LINE0 -> second LINE0 issued after the first completes.
REQ-038 G_TIMEOUT_CYCLES=50, done withheld -> o_timeout_err=1 after 50 wait cycles; next pending command still issues.
REQ-039 rst asserted in S_WAIT of a CGRAM update, 3 pending requests -> all outputs 0 and o_busy=1 next cycle; pending cleared; boot restarts from o_start_init.
REQ-040 Spurious i_control_done in S_IDLE -> no state change, no command pulse.

Source files
------------

// File: rtl/lcd_cfah_sched_pkg.sv
// Shared types and constants for the CFAH LCD command scheduler.
package lcd_cfah_sched_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_ISSUE,
        S_WAIT,
        S_IDLE
    } state_e;

    typedef enum logic [2:0] {
        CMD_INIT,
        CMD_DCTRL,
        CMD_CLEAR,
        CMD_CGRAM,
        CMD_LINE0,
        CMD_LINE1
    } cmd_e;

    // Pending-vector bit positions; a lower index means a higher priority.
    localparam int unsigned N_PEND     = 5;
    localparam int unsigned PRIO_CLEAR = 0;
    localparam int unsigned PRIO_DCTRL = 1;
    localparam int unsigned PRIO_CGRAM = 2;
    localparam int unsigned PRIO_LINE0 = 3;
    localparam int unsigned PRIO_LINE1 = 4;

    // Map a one-hot grant back to the command it selects.
    function automatic cmd_e grant_to_cmd(input logic [N_PEND-1:0] grant);
        cmd_e cmd;
        cmd = CMD_CLEAR;
        if (grant[PRIO_DCTRL]) cmd = CMD_DCTRL;
        if (grant[PRIO_CGRAM]) cmd = CMD_CGRAM;
        if (grant[PRIO_LINE0]) cmd = CMD_LINE0;
        if (grant[PRIO_LINE1]) cmd = CMD_LINE1;
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_cfah_prio_enc.sv
// Fixed-priority arbiter: the lowest set bit of the pending vector wins.
module lcd_cfah_prio_enc
    import lcd_cfah_sched_pkg::*;
(
    input  logic [N_PEND-1:0] i_pend,
    output logic [N_PEND-1:0] o_grant_c
);

    // Isolate the lowest set bit (two's-complement trick).
    always_comb begin
        o_grant_c = i_pend & (~i_pend + N_PEND'(1));
    end

endmodule

// File: rtl/lcd_cfah_cmd_sched.sv
// Command scheduler for lcd_cfah_top: runs the power-up sequence, then
// arbitrates queued refresh requests and issues one command at a time.
module lcd_cfah_cmd_sched
    import lcd_cfah_sched_pkg::*;
#(
    parameter int unsigned G_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned G_CNT_WIDTH      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_clear,
    input  logic       i_req_dctrl,
    input  logic       i_req_cgram,
    input  logic [1:0] i_req_line,
    input  logic       i_control_done,
    output logic       o_start_init,
    output logic       o_display_ctrl_cmd,
    output logic       o_clear_display_cmd,
    output logic       o_update_lcd,
    output logic       o_update_cgram,
    output logic       o_lcd_all_char,
    output logic       o_lcd_line_sel,
    output logic       o_cgram_all_char,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_timeout_err
);

    localparam logic [G_CNT_WIDTH-1:0] TMO_LAST = G_CNT_WIDTH'(G_TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    cmd_e                    boot_cmd_q, boot_cmd_d;
    logic [N_PEND-1:0]       pend_q, pend_d;
    logic [G_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    start_init_q, start_init_d;
    logic                    dctrl_q, dctrl_d;
    logic                    clear_q, clear_d;
    logic                    update_lcd_q, update_lcd_d;
    logic                    update_cgram_q, update_cgram_d;
    logic                    lcd_all_q, lcd_all_d;
    logic                    line_sel_q, line_sel_d;
    logic                    cgram_all_q, cgram_all_d;

    logic [N_PEND-1:0]       req_vec;
    logic [N_PEND-1:0]       grant_c;
    logic                    issue;
    cmd_e                    issue_cmd;

    // Gather the one-cycle request strobes into priority order.
    always_comb begin
        req_vec             = '0;
        req_vec[PRIO_CLEAR] = i_req_clear;
        req_vec[PRIO_DCTRL] = i_req_dctrl;
        req_vec[PRIO_CGRAM] = i_req_cgram;
        req_vec[PRIO_LINE0] = i_req_line[0];
        req_vec[PRIO_LINE1] = i_req_line[1];
    end

    lcd_cfah_prio_enc u_prio_enc (
        .i_pend    (pend_q),
        .o_grant_c (grant_c)
    );

    // Next-state, pending, timeout and registered-output logic.
    always_comb begin
        state_d     = state_q;
        boot_cmd_d  = boot_cmd_q;
        pend_d      = pend_q | req_vec;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        lcd_all_d   = lcd_all_q;
        line_sel_d  = line_sel_q;
        cgram_all_d = cgram_all_q;
        issue       = 1'b0;
        issue_cmd   = boot_cmd_q;

        case (state_q)
            S_BOOT: begin
                issue     = 1'b1;
                issue_cmd = boot_cmd_q;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_control_done || (cnt_q == TMO_LAST)) begin
                    // A timeout abandons the command and carries on as if done.
                    if (!i_control_done) begin
                        err_d = 1'b1;
                    end
                    lcd_all_d   = 1'b0;
                    line_sel_d  = 1'b0;
                    cgram_all_d = 1'b0;
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (boot_cmd_q == CMD_CLEAR) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        boot_cmd_d = (boot_cmd_q == CMD_INIT) ? CMD_DCTRL : CMD_CLEAR;
                        state_d    = S_BOOT;
                    end
                end else begin
                    cnt_d = cnt_q + G_CNT_WIDTH'(1);
                end
            end
            S_IDLE: begin
                if (init_done_q && (pend_q != '0)) begin
                    issue       = 1'b1;
                    issue_cmd   = grant_to_cmd(grant_c);
                    // A same-cycle request on the granted source keeps its flag set.
                    pend_d      = (pend_q & ~grant_c) | req_vec;
                    lcd_all_d   = (issue_cmd == CMD_LINE0) || (issue_cmd == CMD_LINE1);
                    line_sel_d  = (issue_cmd == CMD_LINE1);
                    cgram_all_d = (issue_cmd == CMD_CGRAM);
                    state_d     = S_ISSUE;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        start_init_d   = issue && (issue_cmd == CMD_INIT);
        dctrl_d        = issue && (issue_cmd == CMD_DCTRL);
        clear_d        = issue && (issue_cmd == CMD_CLEAR);
        update_cgram_d = issue && (issue_cmd == CMD_CGRAM);
        update_lcd_d   = issue && ((issue_cmd == CMD_LINE0) || (issue_cmd == CMD_LINE1));
        busy_d         = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_BOOT;
            boot_cmd_q     <= CMD_INIT;
            pend_q         <= '0;
            cnt_q          <= '0;
            init_done_q    <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b1;
            start_init_q   <= 1'b0;
            dctrl_q        <= 1'b0;
            clear_q        <= 1'b0;
            update_lcd_q   <= 1'b0;
            update_cgram_q <= 1'b0;
            lcd_all_q      <= 1'b0;
            line_sel_q     <= 1'b0;
            cgram_all_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            boot_cmd_q     <= boot_cmd_d;
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            init_done_q    <= init_done_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            start_init_q   <= start_init_d;
            dctrl_q        <= dctrl_d;
            clear_q        <= clear_d;
            update_lcd_q   <= update_lcd_d;
            update_cgram_q <= update_cgram_d;
            lcd_all_q      <= lcd_all_d;
            line_sel_q     <= line_sel_d;
            cgram_all_q    <= cgram_all_d;
        end
    end

    assign o_start_init        = start_init_q;
    assign o_display_ctrl_cmd  = dctrl_q;
    assign o_clear_display_cmd = clear_q;
    assign o_update_lcd        = update_lcd_q;
    assign o_update_cgram      = update_cgram_q;
    assign o_lcd_all_char      = lcd_all_q;
    assign o_lcd_line_sel      = line_sel_q;
    assign o_cgram_all_char    = cgram_all_q;
    assign o_busy              = busy_q;
    assign o_init_done         = init_done_q;
    assign o_timeout_err       = err_q;

endmodule
